// File: rtl/uart_boot_loader_ctrl.sv
// Boot loader sequencer: takes a length header and N program words from the UART rx word
// buffer, writes them to instruction memory, then reports ACK/NAK over the UART tx path.
module uart_boot_loader_ctrl #(
  parameter int          ADDR_W    = 14,
  parameter int          MAX_WORDS = 16384,
  parameter int          BASE_ADDR = 0,
  parameter logic [7:0]  ACK_BYTE  = 8'hAA,
  parameter logic [7:0]  NAK_BYTE  = 8'h55
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [31:0]       word_in,
  input  logic              word_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       MAX32 = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SIZE,
    LOAD,
    SEND_ACK,
    SEND_NAK,
    DONE,
    ERR
  } state_t;

  state_t          state;
  logic [ADDR_W:0] size;
  logic [ADDR_W:0] count_inc;

  assign count_inc = word_count + 1'b1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      size       <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE;
      mem_wdata  <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      word_count <= '0;
    end else begin
      mem_we   <= 1'b0;
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          // a word arriving together with start is dropped; the header comes later
          if (start) begin
            state      <= WAIT_SIZE;
            word_count <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
          end
        end
        WAIT_SIZE: begin
          if (word_valid) begin
            if (word_in == '0) begin
              state <= SEND_ACK;
            end else if (word_in > MAX32) begin
              state <= SEND_NAK;
            end else begin
              size  <= word_in[ADDR_W:0];
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (word_valid) begin
            mem_we     <= 1'b1;
            mem_wdata  <= word_in;
            mem_addr   <= BASE + word_count[ADDR_W-1:0];
            word_count <= count_inc;
            if (count_inc == size) begin
              state <= SEND_ACK;
            end
          end
        end
        SEND_ACK: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= ACK_BYTE;
            state    <= DONE;
          end
        end
        SEND_NAK: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= NAK_BYTE;
            state    <= ERR;
          end
        end
        DONE: begin
          if (start) begin
            state      <= WAIT_SIZE;
            word_count <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
          end else begin
            load_done <= 1'b1;
          end
        end
        ERR: begin
          if (start) begin
            state      <= WAIT_SIZE;
            word_count <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
          end else begin
            load_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader_ctrl.sv
// Scoreboard bench for uart_boot_loader_ctrl: stimulus queues expected writes and tx bytes,
// a negedge monitor pops and compares them whenever the DUT strobes mem_we or tx_start.
module tb_uart_boot_loader_ctrl;
  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [31:0] word_in;
  logic        word_valid;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        load_done;
  logic        load_err;
  logic [14:0] word_count;

  uart_boot_loader_ctrl dut (
    .clk(clk), .rstn(rstn), .start(start), .word_in(word_in), .word_valid(word_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .load_done(load_done), .load_err(load_err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [13:0] addr; logic [31:0] data; int cyc; } wr_t;
  typedef struct { logic [7:0] data; int cyc; } tx_t;
  wr_t wq[$];
  tx_t tq[$];

  int checks = 0;
  int errors = 0;
  int last_tx_cyc = -1;
  bit prev_tx = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    wr_t we;
    tx_t te;
    if (mem_we) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write addr=%0h data=%0h expected none", mem_addr, mem_wdata);
      end else begin
        we = wq.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(we.addr));
        chk("wr_data", mem_wdata, we.data);
        chk("wr_cycle", cyc, we.cyc);
      end
    end
    if (tx_start) begin
      last_tx_cyc = cyc;
      if (tq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_tx data=%0h expected none", tx_data);
      end else begin
        te = tq.pop_front();
        chk("tx_data", 32'(tx_data), 32'(te.data));
        if (te.cyc >= 0) chk("tx_cycle", cyc, te.cyc);
      end
      if (prev_tx) begin
        errors++;
        $display("FAIL tx_width got=2+ cycles expected=1");
      end
    end
    prev_tx = tx_start;
    if (load_done && load_err) begin
      errors++;
      $display("FAIL flags_exclusive got=both expected=one");
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    word_valid = 1'b1;
    word_in    = w;
    @(negedge clk);
    word_valid = 1'b0;
  endtask

  task automatic send_data(input logic [31:0] w, input int addr);
    wr_t e;
    e.addr = 14'(addr);
    e.data = w;
    e.cyc  = cyc + 1;
    wq.push_back(e);
    send(w);
  endtask

  task automatic expect_tx(input logic [7:0] b, input int c);
    tx_t e;
    e.data = b;
    e.cyc  = c;
    tq.push_back(e);
  endtask

  task automatic wait_flag(input bit want_err, output int seen);
    seen = -1;
    for (int i = 0; i < 40; i++) begin
      if (want_err ? load_err : load_done) begin
        seen = cyc;
        break;
      end
      @(negedge clk);
    end
    if (seen < 0) begin
      checks++; errors++;
      $display("FAIL wait_%s got=timeout expected=flag high", want_err ? "load_err" : "load_done");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rstn = 1'b0; start = 1'b0; word_in = '0; word_valid = 1'b0; tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_load_done", 32'(load_done), 0);
    chk("rst_load_err", 32'(load_err), 0);
    chk("rst_word_count", 32'(word_count), 0);
    rstn = 1'b1;
    @(negedge clk);

    // three-word load
    pulse_start();
    expect_tx(8'hAA, -1);
    send(32'd3);
    send_data(32'h11111111, 0);
    send_data(32'h22222222, 1);
    send_data(32'h33333333, 2);
    wait_flag(1'b0, seen);
    chk("done_latency", seen, last_tx_cyc + 1);
    chk("t1_word_count", 32'(word_count), 3);
    chk("t1_load_err", 32'(load_err), 0);

    // zero-length header, re-armed from DONE
    pulse_start();
    chk("t2_done_clear", 32'(load_done), 0);
    expect_tx(8'hAA, -1);
    send(32'd0);
    wait_flag(1'b0, seen);
    chk("t2_word_count", 32'(word_count), 0);

    // oversize header, surplus words dropped
    pulse_start();
    expect_tx(8'h55, -1);
    send(32'd16385);
    send(32'h01020304);
    send(32'h05060708);
    wait_flag(1'b1, seen);
    chk("t3_load_done", 32'(load_done), 0);
    chk("t3_word_count", 32'(word_count), 0);

    // tx_busy withholds ACK
    pulse_start();
    chk("t4_err_clear", 32'(load_err), 0);
    tx_busy = 1'b1;
    send(32'd2);
    send_data(32'hA5A5A5A5, 0);
    send_data(32'h5A5A5A5A, 1);
    repeat (10) @(negedge clk);
    expect_tx(8'hAA, cyc + 1);
    tx_busy = 1'b0;
    wait_flag(1'b0, seen);
    chk("t4_word_count", 32'(word_count), 2);

    // reset mid-load, IDLE words ignored, start+word in the same cycle drops the word
    pulse_start();
    send(32'd4);
    send_data(32'hA0A0A0A0, 0);
    send_data(32'hB1B1B1B1, 1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("t5_word_count", 32'(word_count), 0);
    chk("t5_tx_data", 32'(tx_data), 0);
    chk("t5_load_done", 32'(load_done), 0);
    chk("t5_mem_addr", 32'(mem_addr), 0);
    send(32'h00000005);
    start = 1'b1; word_valid = 1'b1; word_in = 32'd1;
    @(negedge clk);
    start = 1'b0; word_valid = 1'b0;
    expect_tx(8'hAA, -1);
    send(32'd1);
    send_data(32'hDEADBEEF, 0);
    wait_flag(1'b0, seen);
    chk("t5_final_count", 32'(word_count), 1);

    // reload after completion; word sent in DONE is ignored
    send(32'h12345678);
    pulse_start();
    chk("t6_done_drop", 32'(load_done), 0);
    expect_tx(8'hAA, -1);
    send(32'd1);
    send_data(32'hCAFEF00D, 0);
    wait_flag(1'b0, seen);
    chk("t6_word_count", 32'(word_count), 1);

    // header with high bits set must be rejected as a full 32-bit value
    pulse_start();
    expect_tx(8'h55, -1);
    send(32'h00010001);
    wait_flag(1'b1, seen);
    chk("t7_load_done", 32'(load_done), 0);
    chk("t7_word_count", 32'(word_count), 0);

    repeat (5) @(negedge clk);
    chk("writes_left", wq.size(), 0);
    chk("tx_left", tq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
